// File: rtl/hazard_rd_tracker.sv
// Tracks destination register and occupancy of the EXE/MEM/WB stages, closes the
// stall loop with the stall controller, and keeps stall statistics plus a stuck-stall watchdog.
module hazard_rd_tracker #(
   parameter int unsigned ALEN          = 5,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned STALL_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_id_valid,
   input  logic [ALEN-1:0]  i_id_rd,
   input  logic             i_id_writes_rd,
   input  logic             i_flush,
   input  logic             i_stall,
   input  logic             i_is_staller,
   input  logic             i_is_mem_staller,
   input  logic             i_is_wb_staller,
   output logic [ALEN-1:0]  o_exe_rd,
   output logic [ALEN-1:0]  o_mem_rd,
   output logic [ALEN-1:0]  o_wb_rd,
   output logic             o_exe_valid,
   output logic             o_mem_valid,
   output logic             o_wb_valid,
   output logic             o_retire,
   output logic             o_pipeline_stalled,
   output logic [CNT_W-1:0] o_exe_stall_cnt,
   output logic [CNT_W-1:0] o_mem_stall_cnt,
   output logic [CNT_W-1:0] o_wb_stall_cnt,
   output logic [CNT_W-1:0] o_ext_stall_cnt,
   output logic             o_deadlock
);

   localparam logic [CNT_W-1:0] CntMax  = '1;
   localparam logic [7:0]       Timeout = 8'(STALL_TIMEOUT);

   logic             exe_valid_q, mem_valid_q, wb_valid_q, exe_valid_d;
   logic [ALEN-1:0]  exe_rd_q, mem_rd_q, wb_rd_q, exe_rd_d;
   logic             stalled_q;
   logic [CNT_W-1:0] exe_cnt_q, mem_cnt_q, wb_cnt_q, ext_cnt_q;
   logic [CNT_W-1:0] exe_cnt_d, mem_cnt_d, wb_cnt_d, ext_cnt_d;
   logic [7:0]       run_q, run_d;
   logic             deadlock_q, deadlock_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CntMax) ? v : v + CNT_W'(1);
   endfunction

   // Stall or flush both turn the EXE load into a bubble; rd is zeroed when nothing is written.
   always_comb begin
      exe_valid_d = 1'b0;
      exe_rd_d    = '0;
      if (!i_stall && !i_flush) begin
         exe_valid_d = i_id_valid;
         exe_rd_d    = (i_id_valid && i_id_writes_rd) ? i_id_rd : '0;
      end
   end

   always_comb begin
      exe_cnt_d = exe_cnt_q;
      mem_cnt_d = mem_cnt_q;
      wb_cnt_d  = wb_cnt_q;
      ext_cnt_d = ext_cnt_q;
      if (i_stall) begin
         if (i_is_staller)          exe_cnt_d = sat_inc(exe_cnt_q);
         else if (i_is_mem_staller) mem_cnt_d = sat_inc(mem_cnt_q);
         else if (i_is_wb_staller)  wb_cnt_d  = sat_inc(wb_cnt_q);
         else                       ext_cnt_d = sat_inc(ext_cnt_q);
      end
   end

   // Watchdog compares the post-edge run length so the flag rises on the timeout edge itself.
   always_comb begin
      run_d      = i_stall ? ((run_q == 8'hff) ? run_q : run_q + 8'd1) : 8'd0;
      deadlock_d = deadlock_q | (run_d >= Timeout);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exe_valid_q <= 1'b0;
         mem_valid_q <= 1'b0;
         wb_valid_q  <= 1'b0;
         exe_rd_q    <= '0;
         mem_rd_q    <= '0;
         wb_rd_q     <= '0;
         stalled_q   <= 1'b0;
         exe_cnt_q   <= '0;
         mem_cnt_q   <= '0;
         wb_cnt_q    <= '0;
         ext_cnt_q   <= '0;
         run_q       <= '0;
         deadlock_q  <= 1'b0;
      end else begin
         exe_valid_q <= exe_valid_d;
         exe_rd_q    <= exe_rd_d;
         mem_valid_q <= exe_valid_q;
         mem_rd_q    <= exe_rd_q;
         wb_valid_q  <= mem_valid_q;
         wb_rd_q     <= mem_rd_q;
         stalled_q   <= i_stall;
         exe_cnt_q   <= exe_cnt_d;
         mem_cnt_q   <= mem_cnt_d;
         wb_cnt_q    <= wb_cnt_d;
         ext_cnt_q   <= ext_cnt_d;
         run_q       <= run_d;
         deadlock_q  <= deadlock_d;
      end
   end

   assign o_exe_rd           = exe_rd_q;
   assign o_mem_rd           = mem_rd_q;
   assign o_wb_rd            = wb_rd_q;
   assign o_exe_valid        = exe_valid_q;
   assign o_mem_valid        = mem_valid_q;
   assign o_wb_valid         = wb_valid_q;
   assign o_retire           = wb_valid_q;
   assign o_pipeline_stalled = stalled_q;
   assign o_exe_stall_cnt    = exe_cnt_q;
   assign o_mem_stall_cnt    = mem_cnt_q;
   assign o_wb_stall_cnt     = wb_cnt_q;
   assign o_ext_stall_cnt    = ext_cnt_q;
   assign o_deadlock         = deadlock_q;

endmodule

// File: tb/tb_hazard_rd_tracker.sv
// Scoreboarded bench for hazard_rd_tracker: retiring rd values are checked by a monitor,
// stage/counter/watchdog state by directed checks.
module tb_hazard_rd_tracker;

   localparam int unsigned ALEN  = 5;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             i_id_valid, i_id_writes_rd, i_flush, i_stall;
   logic [ALEN-1:0]  i_id_rd;
   logic             i_is_staller, i_is_mem_staller, i_is_wb_staller;
   logic [ALEN-1:0]  o_exe_rd, o_mem_rd, o_wb_rd;
   logic             o_exe_valid, o_mem_valid, o_wb_valid, o_retire;
   logic             o_pipeline_stalled, o_deadlock;
   logic [CNT_W-1:0] o_exe_stall_cnt, o_mem_stall_cnt, o_wb_stall_cnt, o_ext_stall_cnt;

   int tests  = 0;
   int errors = 0;
   logic [ALEN-1:0] exp_q[$];

   hazard_rd_tracker #(.ALEN(ALEN), .CNT_W(CNT_W), .STALL_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_id_valid(i_id_valid), .i_id_rd(i_id_rd), .i_id_writes_rd(i_id_writes_rd),
      .i_flush(i_flush), .i_stall(i_stall),
      .i_is_staller(i_is_staller), .i_is_mem_staller(i_is_mem_staller),
      .i_is_wb_staller(i_is_wb_staller),
      .o_exe_rd(o_exe_rd), .o_mem_rd(o_mem_rd), .o_wb_rd(o_wb_rd),
      .o_exe_valid(o_exe_valid), .o_mem_valid(o_mem_valid), .o_wb_valid(o_wb_valid),
      .o_retire(o_retire), .o_pipeline_stalled(o_pipeline_stalled),
      .o_exe_stall_cnt(o_exe_stall_cnt), .o_mem_stall_cnt(o_mem_stall_cnt),
      .o_wb_stall_cnt(o_wb_stall_cnt), .o_ext_stall_cnt(o_ext_stall_cnt),
      .o_deadlock(o_deadlock)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {27'd0, o_exe_rd, o_mem_rd, o_wb_rd, o_exe_valid, o_mem_valid, o_wb_valid,
              o_retire, o_pipeline_stalled, o_exe_stall_cnt, o_mem_stall_cnt,
              o_wb_stall_cnt, o_ext_stall_cnt, o_deadlock};
   endfunction

   // Monitor: every retire pulse must match the oldest expected rd.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && o_retire === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_retire", {59'd0, o_wb_rd}, 64'h3f);
         end else begin
            check("retire_rd", {59'd0, o_wb_rd}, {59'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [ALEN-1:0] rd, input logic wr,
                        input logic fl, input logic st, input logic [2:0] cause);
      i_id_valid       = v;
      i_id_rd          = rd;
      i_id_writes_rd   = wr;
      i_flush          = fl;
      i_stall          = st;
      {i_is_staller, i_is_mem_staller, i_is_wb_staller} = cause;
      if (v && !fl && !st) exp_q.push_back(wr ? rd : '0);
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   // Async reset pulse between edges; in-flight instructions must never retire.
   task automatic reset_pulse(input string name);
      rst_n = 1'b0;
      #1;
      check(name, all_outs(), 64'd0);
      exp_q.delete();
      idle();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset with random inputs
      rst_n            = 1'b0;
      i_id_valid       = 1'($urandom);
      i_id_rd          = ALEN'($urandom);
      i_id_writes_rd   = 1'($urandom);
      i_flush          = 1'($urandom);
      i_stall          = 1'($urandom);
      i_is_staller     = 1'($urandom);
      i_is_mem_staller = 1'($urandom);
      i_is_wb_staller  = 1'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", all_outs(), 64'd0);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      check("post_release_idle", all_outs(), 64'd0);

      // Basic latency; also rd not written and rd=x0
      drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
      tick();
      check("exe_rd_5", {58'd0, o_exe_valid, o_exe_rd}, {58'd0, 1'b1, 5'd5});
      drive(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 3'b000);
      tick();
      check("mem_rd_5", {59'd0, o_mem_rd}, 64'd5);
      check("exe_no_write", {58'd0, o_exe_valid, o_exe_rd}, {58'd0, 1'b1, 5'd0});
      drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
      tick();
      check("wb_rd_5_retire", {58'd0, o_retire, o_wb_rd}, {58'd0, 1'b1, 5'd5});
      check("exe_x0", {58'd0, o_exe_valid, o_exe_rd}, {58'd0, 1'b1, 5'd0});
      idle();
      repeat (3) tick();
      check("drained", {61'd0, o_exe_valid, o_mem_valid, o_wb_valid}, 64'd0);

      // Stall walk with exe, mem, wb causes
      drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
      tick();
      drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 3'b100);
      tick();
      check("stall1", {57'd0, o_exe_valid, o_exe_rd, o_pipeline_stalled},
            {57'd0, 1'b0, 5'd0, 1'b1});
      check("stall1_mem", {59'd0, o_mem_rd}, 64'd5);
      drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 3'b010);
      tick();
      check("stall2", {58'd0, o_wb_rd, o_pipeline_stalled}, {58'd0, 5'd5, 1'b1});
      drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 3'b001);
      tick();
      check("stall3", {62'd0, o_wb_valid, o_pipeline_stalled}, {62'd0, 1'b0, 1'b1});
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b111);
      tick();
      check("stall_released", {63'd0, o_pipeline_stalled}, 64'd0);
      check("cause_counts", {48'd0, o_exe_stall_cnt, o_mem_stall_cnt, o_wb_stall_cnt,
            o_ext_stall_cnt}, {48'd0, 4'd1, 4'd1, 4'd1, 4'd0});
      check("no_deadlock_short", {63'd0, o_deadlock}, 64'd0);

      // Flush, then flush together with stall
      drive(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000);
      tick();
      check("flush_bubble", {58'd0, o_exe_valid, o_exe_rd}, 64'd0);
      drive(1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 3'b000);
      tick();
      check("flush_stall_bubble", {58'd0, o_exe_valid, o_exe_rd}, 64'd0);
      idle();
      repeat (3) tick();
      check("flush_no_retire", {63'd0, o_wb_valid}, 64'd0);

      // Watchdog: 10 stall cycles, no cause
      reset_pulse("reset_before_watchdog");
      for (int k = 1; k <= 10; k++) begin
         drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000);
         tick();
         check($sformatf("deadlock_edge%0d", k), {63'd0, o_deadlock}, {63'd0, k >= 8});
      end
      idle();
      tick();
      check("deadlock_sticky", {63'd0, o_deadlock}, 64'd1);
      check("ext_cnt_10", {60'd0, o_ext_stall_cnt}, 64'd10);

      // Saturation and priority: all causes high, exe wins
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 3'b111);
         tick();
      end
      idle();
      tick();
      check("exe_cnt_sat", {48'd0, o_exe_stall_cnt, o_mem_stall_cnt, o_wb_stall_cnt,
            o_ext_stall_cnt}, {48'd0, 4'd15, 4'd0, 4'd0, 4'd10});

      // Reset mid-flight: instruction in MEM must never retire
      drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
      tick();
      idle();
      tick();
      check("inflight_mem", {59'd0, o_mem_rd}, 64'd3);
      reset_pulse("reset_midstream");
      repeat (4) tick();
      check("after_reset_idle", all_outs(), 64'd0);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
